// File: rtl/xif_copro_prog_predecoder_if.sv
// ----------------------------------------------------------------------------
// xif_copro_prog_predecoder_if
// Issue and response channels between the core's XIF issue port and the
// programmable predecoder.
//   issue_*  : valid/ready offer of one instruction word plus its id
//   resp_*   : valid/ready return of the registered predecode result
// Modports:
//   master : core side (drives issue, consumes response)
//   slave  : predecoder side
// ----------------------------------------------------------------------------
interface xif_copro_prog_predecoder_if #(
    parameter int ID_W  = 4,
    parameter int IDX_W = 3
);
    logic             issue_valid_i;
    logic             issue_ready_o;
    logic [31:0]      issue_instr_i;
    logic [ID_W-1:0]  issue_id_i;

    logic             resp_valid_o;
    logic             resp_ready_i;
    logic [ID_W-1:0]  resp_id_o;
    logic             resp_hit_o;
    logic [IDX_W-1:0] resp_hit_idx_o;
    logic             resp_accept_o;
    logic             resp_loadstore_o;
    logic             resp_writeback_o;
    logic [1:0]       resp_use_gprs_o;

    modport master (
        output issue_valid_i, issue_instr_i, issue_id_i, resp_ready_i,
        input  issue_ready_o, resp_valid_o, resp_id_o, resp_hit_o,
               resp_hit_idx_o, resp_accept_o, resp_loadstore_o,
               resp_writeback_o, resp_use_gprs_o
    );

    modport slave (
        input  issue_valid_i, issue_instr_i, issue_id_i, resp_ready_i,
        output issue_ready_o, resp_valid_o, resp_id_o, resp_hit_o,
               resp_hit_idx_o, resp_accept_o, resp_loadstore_o,
               resp_writeback_o, resp_use_gprs_o
    );
endinterface

// File: rtl/xif_copro_prog_predecoder.sv
// ----------------------------------------------------------------------------
// xif_copro_prog_predecoder
// Runtime-programmable XIF issue predecoder. Each offered instruction is
// matched against NUM_ENTRIES mask/match entries (lowest enabled hit wins)
// and the attribute set of the winner is returned one cycle later through a
// valid/ready response register.
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   xif (slave)       : issue and response channels
//   cfg_*             : table write port (one entry per cycle)
//   stat_clr_i        : clear hit/miss counters
//   stat_*_cnt_o      : saturating hit/miss counters
// Build option:
//   XIF_COPRO_PRD_STATS_EN : enables the hit/miss counters; otherwise they
//                            read as zero and stat_clr_i is ignored.
// ----------------------------------------------------------------------------
module xif_copro_prog_predecoder #(
    parameter int NUM_ENTRIES = 8,
    parameter int ID_W        = 4,
    parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    xif_copro_prog_predecoder_if.slave xif,
    input  logic                       cfg_we_i,
    input  logic [IDX_W-1:0]           cfg_idx_i,
    input  logic                       cfg_en_i,
    input  logic [31:0]                cfg_instr_i,
    input  logic [31:0]                cfg_mask_i,
    input  logic [4:0]                 cfg_attr_i,
    input  logic                       stat_clr_i,
    output logic [15:0]                stat_hit_cnt_o,
    output logic [15:0]                stat_miss_cnt_o
);

    // attr layout: [4]=accept [3]=loadstore [2]=writeback [1:0]=use_gprs
    logic [NUM_ENTRIES-1:0] en_q;
    logic [31:0]            pat_q  [NUM_ENTRIES];
    logic [31:0]            mask_q [NUM_ENTRIES];
    logic [4:0]             attr_q [NUM_ENTRIES];

    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic [4:0]             hit_attr;

    logic                   issue_ready;
    logic                   xfer;

    logic                   resp_valid_q;
    logic [ID_W-1:0]        resp_id_q;
    logic                   resp_hit_q;
    logic [IDX_W-1:0]       resp_idx_q;
    logic [4:0]             resp_attr_q;

    // Indices at or above NUM_ENTRIES never compare equal, so such writes
    // fall through without touching the table.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                pat_q[i]  <= '0;
                mask_q[i] <= '0;
                attr_q[i] <= '0;
            end
        end else if (cfg_we_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (cfg_idx_i == IDX_W'(i)) begin
                    en_q[i]   <= cfg_en_i;
                    pat_q[i]  <= cfg_instr_i;
                    mask_q[i] <= cfg_mask_i;
                    attr_q[i] <= cfg_attr_i;
                end
            end
        end
    end

    // Walk from the top down so the lowest matching index is the last
    // assignment and therefore wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_attr = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (en_q[i] && (((xif.issue_instr_i ^ pat_q[i]) & mask_q[i]) == 32'd0)) begin
                hit      = 1'b1;
                hit_idx  = IDX_W'(i);
                hit_attr = attr_q[i];
            end
        end
    end

    // Held low during reset even though the response register is empty.
    assign issue_ready = !rst_i && (!resp_valid_q || xif.resp_ready_i);
    assign xfer        = xif.issue_valid_i && issue_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_hit_q   <= 1'b0;
            resp_idx_q   <= '0;
            resp_attr_q  <= '0;
        end else if (xfer) begin
            resp_valid_q <= 1'b1;
            resp_id_q    <= xif.issue_id_i;
            resp_hit_q   <= hit;
            resp_idx_q   <= hit_idx;
            resp_attr_q  <= hit_attr;
        end else if (xif.resp_ready_i) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign xif.issue_ready_o    = issue_ready;
    assign xif.resp_valid_o     = resp_valid_q;
    assign xif.resp_id_o        = resp_id_q;
    assign xif.resp_hit_o       = resp_hit_q;
    assign xif.resp_hit_idx_o   = resp_idx_q;
    assign xif.resp_accept_o    = resp_attr_q[4];
    assign xif.resp_loadstore_o = resp_attr_q[3];
    assign xif.resp_writeback_o = resp_attr_q[2];
    assign xif.resp_use_gprs_o  = resp_attr_q[1:0];

`ifdef XIF_COPRO_PRD_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (stat_clr_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (xfer) begin
            if (hit && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (!hit && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign stat_hit_cnt_o  = hit_cnt_q;
    assign stat_miss_cnt_o = miss_cnt_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr_i;
    assign stat_hit_cnt_o  = '0;
    assign stat_miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_xif_copro_prog_predecoder.sv
module tb_xif_copro_prog_predecoder;

    localparam int NUM_ENTRIES = 6;
    localparam int ID_W        = 4;
    localparam int IDX_W       = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic        cfg_en;
    logic [31:0] cfg_instr;
    logic [31:0] cfg_mask;
    logic [4:0]  cfg_attr;
    logic        stat_clr;
    logic [15:0] stat_hit_cnt;
    logic [15:0] stat_miss_cnt;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] W_HIT  = 32'h0402F02B;
    localparam logic [31:0] W_MISS = 32'h00000013;

    xif_copro_prog_predecoder_if #(.ID_W(ID_W), .IDX_W(IDX_W)) bus ();

    xif_copro_prog_predecoder #(
        .NUM_ENTRIES(NUM_ENTRIES),
        .ID_W       (ID_W),
        .IDX_W      (IDX_W)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .xif            (bus),
        .cfg_we_i       (cfg_we),
        .cfg_idx_i      (cfg_idx),
        .cfg_en_i       (cfg_en),
        .cfg_instr_i    (cfg_instr),
        .cfg_mask_i     (cfg_mask),
        .cfg_attr_i     (cfg_attr),
        .stat_clr_i     (stat_clr),
        .stat_hit_cnt_o (stat_hit_cnt),
        .stat_miss_cnt_o(stat_miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_cfg(input logic [IDX_W-1:0] idx, input logic en, input logic [31:0] pat,
                          input logic [31:0] mask, input logic [4:0] attr);
        cfg_idx   = idx;
        cfg_en    = en;
        cfg_instr = pat;
        cfg_mask  = mask;
        cfg_attr  = attr;
        cfg_we    = 1'b1;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [ID_W-1:0] id);
        bus.issue_valid_i = 1'b1;
        bus.issue_instr_i = instr;
        bus.issue_id_i    = id;
        tick();
        bus.issue_valid_i = 1'b0;
    endtask

    initial begin
        rst               = 1'b1;
        cfg_we            = 1'b0;
        cfg_idx           = '0;
        cfg_en            = 1'b0;
        cfg_instr         = '0;
        cfg_mask          = '0;
        cfg_attr          = '0;
        stat_clr          = 1'b0;
        bus.issue_valid_i = 1'b0;
        bus.issue_instr_i = '0;
        bus.issue_id_i    = '0;
        bus.resp_ready_i  = 1'b1;
        #2;
        chk("rst_issue_ready", bus.issue_ready_o, 0);
        chk("rst_resp_valid", bus.resp_valid_o, 0);
        chk("rst_resp_hit", bus.resp_hit_o, 0);
        chk("rst_resp_accept", bus.resp_accept_o, 0);
        chk("rst_hit_cnt", stat_hit_cnt, 0);
        chk("rst_miss_cnt", stat_miss_cnt, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("idle_issue_ready", bus.issue_ready_o, 1);

        // Empty table: every instruction misses
        issue(W_HIT, 4'd1);
        chk("empty_valid", bus.resp_valid_o, 1);
        chk("empty_hit", bus.resp_hit_o, 0);
        chk("empty_accept", bus.resp_accept_o, 0);
        chk("empty_id", bus.resp_id_o, 1);
        tick();
        chk("consume_clears_valid", bus.resp_valid_o, 0);

        // Single entry hit
        wr_cfg(3'd0, 1'b1, 32'h0400702B, 32'hFE00707F, 5'b10001);
        issue(W_HIT, 4'd3);
        chk("e0_hit", bus.resp_hit_o, 1);
        chk("e0_idx", bus.resp_hit_idx_o, 0);
        chk("e0_accept", bus.resp_accept_o, 1);
        chk("e0_loadstore", bus.resp_loadstore_o, 0);
        chk("e0_writeback", bus.resp_writeback_o, 0);
        chk("e0_gprs", bus.resp_use_gprs_o, 2'b01);
        chk("e0_id", bus.resp_id_o, 3);

        // Priority: lowest index wins, then entry1 once entry0 is disabled
        wr_cfg(3'd1, 1'b1, 32'h0400702B, 32'h0000007F, 5'b10010);
        issue(W_HIT, 4'd4);
        chk("prio_idx0", bus.resp_hit_idx_o, 0);
        wr_cfg(3'd0, 1'b0, 32'h0400702B, 32'hFE00707F, 5'b10001);
        issue(W_HIT, 4'd5);
        chk("prio_idx1", bus.resp_hit_idx_o, 1);
        chk("prio_gprs", bus.resp_use_gprs_o, 2'b10);
        chk("prio_accept", bus.resp_accept_o, 1);

        // Back-to-back throughput
        bus.issue_valid_i = 1'b1;
        bus.issue_instr_i = W_HIT;
        bus.issue_id_i    = 4'd7;
        tick();
        chk("b2b_a_id", bus.resp_id_o, 7);
        chk("b2b_a_hit", bus.resp_hit_o, 1);
        bus.issue_instr_i = W_MISS;
        bus.issue_id_i    = 4'd8;
        tick();
        bus.issue_valid_i = 1'b0;
        chk("b2b_b_valid", bus.resp_valid_o, 1);
        chk("b2b_b_id", bus.resp_id_o, 8);
        chk("b2b_b_hit", bus.resp_hit_o, 0);
        tick();

        // Backpressure: first response held, second waits for ready
        wr_cfg(3'd0, 1'b1, 32'h0400702B, 32'hFE00707F, 5'b10001);
        bus.resp_ready_i  = 1'b0;
        bus.issue_valid_i = 1'b1;
        bus.issue_instr_i = W_HIT;
        bus.issue_id_i    = 4'd9;
        tick();
        bus.issue_instr_i = W_MISS;
        bus.issue_id_i    = 4'd10;
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", bus.resp_valid_o, 1);
            chk("bp_id", bus.resp_id_o, 9);
            chk("bp_hit", bus.resp_hit_o, 1);
            chk("bp_issue_ready", bus.issue_ready_o, 0);
            tick();
        end
        bus.resp_ready_i = 1'b1;
        #1;
        chk("bp_ready_rises", bus.issue_ready_o, 1);
        tick();
        bus.issue_valid_i = 1'b0;
        chk("bp_second_valid", bus.resp_valid_o, 1);
        chk("bp_second_id", bus.resp_id_o, 10);
        chk("bp_second_hit", bus.resp_hit_o, 0);
        tick();
        chk("bp_no_duplicate", bus.resp_valid_o, 0);

        // Same-cycle config write and issue: old table applies
        cfg_idx           = 3'd0;
        cfg_en            = 1'b0;
        cfg_instr         = 32'h0400702B;
        cfg_mask          = 32'hFE00707F;
        cfg_attr          = 5'b10001;
        cfg_we            = 1'b1;
        bus.issue_valid_i = 1'b1;
        bus.issue_instr_i = W_HIT;
        bus.issue_id_i    = 4'd11;
        tick();
        cfg_we            = 1'b0;
        bus.issue_valid_i = 1'b0;
        chk("samecyc_old_idx", bus.resp_hit_idx_o, 0);
        chk("samecyc_old_gprs", bus.resp_use_gprs_o, 2'b01);
        issue(W_HIT, 4'd12);
        chk("samecyc_new_idx", bus.resp_hit_idx_o, 1);

        // Held response is not altered by a config write
        bus.resp_ready_i = 1'b0;
        issue(W_HIT, 4'd13);
        wr_cfg(3'd1, 1'b0, 32'h0, 32'h0, 5'b00000);
        chk("held_hit", bus.resp_hit_o, 1);
        chk("held_idx", bus.resp_hit_idx_o, 1);
        chk("held_gprs", bus.resp_use_gprs_o, 2'b10);
        bus.resp_ready_i = 1'b1;
        tick();

        // Out-of-range index ignored; catch-all at top index; accept=0 still hits
        wr_cfg(3'd6, 1'b1, 32'h0, 32'h0, 5'b11111);
        issue(W_MISS, 4'd14);
        chk("oor_ignored_hit", bus.resp_hit_o, 0);
        chk("oor_ignored_accept", bus.resp_accept_o, 0);
        wr_cfg(3'd5, 1'b1, 32'h0, 32'h0, 5'b01000);
        issue(W_MISS, 4'd15);
        chk("catchall_hit", bus.resp_hit_o, 1);
        chk("catchall_idx", bus.resp_hit_idx_o, 5);
        chk("catchall_accept", bus.resp_accept_o, 0);
        chk("catchall_loadstore", bus.resp_loadstore_o, 1);

        // Async reset while a response is pending
        bus.resp_ready_i = 1'b0;
        issue(W_MISS, 4'd1);
        chk("prerst_valid", bus.resp_valid_o, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_valid", bus.resp_valid_o, 0);
        chk("midrst_issue_ready", bus.issue_ready_o, 0);
        chk("midrst_hit", bus.resp_hit_o, 0);
        tick();
        rst = 1'b0;
        bus.resp_ready_i = 1'b1;
        tick();
        chk("postrst_no_replay", bus.resp_valid_o, 0);
        issue(W_MISS, 4'd2);
        chk("postrst_table_cleared", bus.resp_hit_o, 0);

`ifdef XIF_COPRO_PRD_STATS_EN
        wr_cfg(3'd0, 1'b1, 32'h0400702B, 32'hFE00707F, 5'b10001);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("stat_clr_hit", stat_hit_cnt, 0);
        chk("stat_clr_miss", stat_miss_cnt, 0);
        issue(W_HIT, 4'd1);
        issue(W_MISS, 4'd2);
        issue(W_HIT, 4'd3);
        issue(W_MISS, 4'd4);
        issue(W_HIT, 4'd5);
        chk("stat_hit_3", stat_hit_cnt, 3);
        chk("stat_miss_2", stat_miss_cnt, 2);
        stat_clr          = 1'b1;
        bus.issue_valid_i = 1'b1;
        bus.issue_instr_i = W_HIT;
        tick();
        stat_clr          = 1'b0;
        bus.issue_valid_i = 1'b0;
        chk("stat_clr_prio_hit", stat_hit_cnt, 0);
        chk("stat_clr_prio_miss", stat_miss_cnt, 0);
        bus.issue_valid_i = 1'b1;
        bus.issue_instr_i = W_HIT;
        repeat (65535) tick();
        chk("stat_reach_max", stat_hit_cnt, 16'hFFFF);
        tick();
        bus.issue_valid_i = 1'b0;
        chk("stat_saturate", stat_hit_cnt, 16'hFFFF);
        chk("stat_sat_miss", stat_miss_cnt, 0);
`else
        stat_clr = 1'b1;
        issue(W_MISS, 4'd3);
        stat_clr = 1'b0;
        issue(W_MISS, 4'd4);
        chk("nostat_hit", stat_hit_cnt, 0);
        chk("nostat_miss", stat_miss_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
